scoreboard_regfile: RTL and testbench

Parametrised general-purpose register file for the pipelined CPU, replacing the fixed 4×16 two-read-port file. Adds configurable width, depth and read-port count, write-through bypass on every read port, a per-register pending-write scoreboard that hazard logic in ID uses to stall, a registered WWD output port with a valid strobe, and a retired-instruction counter. It sits in ID for reads, with writes and retirements driven from WB.

---
 rtl/scoreboard_regfile.sv | 135 +++++++++++++
 tb/tb_scoreboard_regfile.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// ============================================================================
// scoreboard_regfile : parametrised register file with write bypass,
//                      per-register pending-write scoreboard, WWD port and
//                      retired-instruction counter.   Rev 1.0
// ============================================================================
`default_nettype none

module scoreboard_regfile #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int NUM_RD   = 2,
    parameter int PEND_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic                     wwd,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     ret_en,
    input  logic [ADDR_W-1:0]        ret_addr,
    output logic [WIDTH-1:0]         out_port,
    output logic                     out_valid,
    output logic                     iss_ovf,
    output logic                     ret_unf,
    output logic [WIDTH-1:0]         num_retired
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    logic [WIDTH-1:0]  regs     [DEPTH];
    logic [PEND_W-1:0] cnt      [DEPTH];
    logic [PEND_W-1:0] cnt_next [DEPTH];

    logic wr_arr;
    logic wwd_wr;
    logic iss_ok;
    logic ret_ok;
    logic same_reg;
    logic ovf_next;
    logic unf_next;

    assign wr_arr   = wr_en && !wwd && addr_ok(wr_addr);
    assign wwd_wr   = wr_en && wwd;
    assign iss_ok   = iss_en && addr_ok(iss_addr);
    assign ret_ok   = ret_en && addr_ok(ret_addr);
    // A simultaneous reserve and release of one register cancel out.
    assign same_reg = iss_ok && ret_ok && (iss_addr == ret_addr);

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] port_addr;
            logic [WIDTH-1:0]  port_data;
            logic              port_busy;

            assign port_addr = rd_addr[k*ADDR_W +: ADDR_W];

            always_comb begin
                port_data = '0;
                port_busy = 1'b0;
                if (addr_ok(port_addr)) begin
                    port_data = (wr_arr && (wr_addr == port_addr)) ? wr_data : regs[port_addr];
                    // Last reservation retiring now: its value arrives via the bypass.
                    port_busy = (cnt[port_addr] != '0) &&
                                !(ret_ok && (ret_addr == port_addr) && (cnt[port_addr] == CNT_ONE));
                end
            end

            assign rd_data[k*WIDTH +: WIDTH] = port_data;
            assign rd_busy[k]                = port_busy;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next[i] = cnt[i];
            if (!same_reg) begin
                if (iss_ok && (iss_addr == ADDR_W'(i)) && (cnt[i] != CNT_MAX))
                    cnt_next[i] = cnt[i] + CNT_ONE;
                if (ret_ok && (ret_addr == ADDR_W'(i)) && (cnt[i] != '0))
                    cnt_next[i] = cnt[i] - CNT_ONE;
            end
        end
        ovf_next = iss_ok && !same_reg && (cnt[iss_addr] == CNT_MAX);
        unf_next = ret_ok && !same_reg && (cnt[ret_addr] == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (wr_arr)
                regs[wr_addr] <= wr_data;
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= cnt_next[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port    <= '0;
            out_valid   <= 1'b0;
            iss_ovf     <= 1'b0;
            ret_unf     <= 1'b0;
            num_retired <= '0;
        end else begin
            out_valid <= wwd_wr;
            iss_ovf   <= ovf_next;
            ret_unf   <= unf_next;
            if (wwd_wr)
                out_port <= wr_data;
            // Every retirement counts, squashed or not, whatever its address.
            if (ret_en)
                num_retired <= num_retired + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_regfile.sv
// Testbench for scoreboard_regfile: reference model with per-cycle compare,
// directed scenarios and randomized traffic; second instance with 8 registers.
`default_nettype none

module tb_scoreboard_regfile;

    logic        clk;
    logic        reset_n;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en, wwd, iss_en, ret_en;
    logic [1:0]  wr_addr, iss_addr, ret_addr;
    logic [15:0] wr_data;
    logic [15:0] out_port, num_retired;
    logic        out_valid, iss_ovf, ret_unf;

    logic [11:0] b_rd_addr;
    logic [23:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en, b_wwd, b_iss_en, b_ret_en;
    logic [3:0]  b_wr_addr, b_iss_addr, b_ret_addr;
    logic [7:0]  b_wr_data, b_out_port, b_num_retired;
    logic        b_out_valid, b_iss_ovf, b_ret_unf;

    int checks   = 0;
    int failures = 0;

    scoreboard_regfile u_dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wwd(wwd), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .ret_en(ret_en), .ret_addr(ret_addr),
        .out_port(out_port), .out_valid(out_valid), .iss_ovf(iss_ovf),
        .ret_unf(ret_unf), .num_retired(num_retired)
    );

    scoreboard_regfile #(.WIDTH(8), .NUM_REGS(8), .ADDR_W(4), .NUM_RD(3), .PEND_W(2)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wwd(b_wwd), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr), .ret_en(b_ret_en), .ret_addr(b_ret_addr),
        .out_port(b_out_port), .out_valid(b_out_valid), .iss_ovf(b_iss_ovf),
        .ret_unf(b_ret_unf), .num_retired(b_num_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model of the default instance: plain arrays and integers.
    logic [15:0] m_reg [4];
    int          m_cnt [4];
    logic [15:0] m_out_port, m_retired;
    logic        m_out_valid, m_iss_ovf, m_ret_unf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_reg[i] = 16'h0;
                m_cnt[i] = 0;
            end
            m_out_port = 16'h0; m_retired = 16'h0;
            m_out_valid = 1'b0; m_iss_ovf = 1'b0; m_ret_unf = 1'b0;
        end else begin
            m_out_valid = 1'b0; m_iss_ovf = 1'b0; m_ret_unf = 1'b0;
            if (wr_en && !wwd) m_reg[wr_addr] = wr_data;
            if (wr_en && wwd) begin
                m_out_port  = wr_data;
                m_out_valid = 1'b1;
            end
            if (ret_en) m_retired = m_retired + 16'd1;
            if (!(iss_en && ret_en && iss_addr == ret_addr)) begin
                if (iss_en) begin
                    if (m_cnt[iss_addr] == 3) m_iss_ovf = 1'b1;
                    else m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
                end
                if (ret_en) begin
                    if (m_cnt[ret_addr] == 0) m_ret_unf = 1'b1;
                    else m_cnt[ret_addr] = m_cnt[ret_addr] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  a;
            logic [15:0] exp_d;
            logic        exp_b;
            a     = rd_addr[k*2 +: 2];
            exp_d = (wr_en && !wwd && wr_addr == a) ? wr_data : m_reg[a];
            exp_b = (m_cnt[a] != 0) && !(ret_en && ret_addr == a && m_cnt[a] == 1);
            check("model_rd_data", 32'(rd_data[k*16 +: 16]), 32'(exp_d));
            check("model_rd_busy", 32'(rd_busy[k]), 32'(exp_b));
        end
        check("model_out_port", 32'(out_port), 32'(m_out_port));
        check("model_out_valid", 32'(out_valid), 32'(m_out_valid));
        check("model_iss_ovf", 32'(iss_ovf), 32'(m_iss_ovf));
        check("model_ret_unf", 32'(ret_unf), 32'(m_ret_unf));
        check("model_num_retired", 32'(num_retired), 32'(m_retired));
    end

    initial begin
        reset_n = 1'b0;
        rd_addr = '0; wr_en = 0; wwd = 0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0; ret_en = 0; ret_addr = '0;
        b_rd_addr = '0; b_wr_en = 0; b_wwd = 0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_en = 0; b_iss_addr = '0; b_ret_en = 0; b_ret_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_busy", 32'(rd_busy), 32'h0);
        check("reset_out_port", 32'(out_port), 32'h0);
        check("reset_num_retired", 32'(num_retired), 32'h0);

        // Write r1 with both ports reading it: bypass, then array.
        wr_en = 1; wr_addr = 2'd1; wr_data = 16'h1234; rd_addr = {2'd1, 2'd1};
        #1 check("bypass_same_cycle", rd_data, 32'h12341234);
        tick; wr_en = 0;
        #1 check("array_next_cycle", rd_data, 32'h12341234);
        wr_en = 1; wwd = 1; wr_data = 16'hBEEF;
        tick; wr_en = 0; wwd = 0;
        #1;
        check("wwd_out_port", 32'(out_port), 32'hBEEF);
        check("wwd_out_valid", 32'(out_valid), 32'h1);
        check("wwd_array_untouched", rd_data, 32'h12341234);
        tick;
        check("wwd_valid_pulse_end", 32'(out_valid), 32'h0);

        // Saturate r2, then drain it.
        rd_addr = {2'd3, 2'd2}; iss_en = 1; iss_addr = 2'd2;
        repeat (3) tick;
        check("iss3_busy", 32'(rd_busy[0]), 32'h1);
        check("iss3_no_ovf", 32'(iss_ovf), 32'h0);
        tick; iss_en = 0;
        #1 check("iss4_ovf", 32'(iss_ovf), 32'h1);
        tick;
        check("ovf_pulse_end", 32'(iss_ovf), 32'h0);
        ret_en = 1; ret_addr = 2'd2;
        tick; tick;
        #1 check("last_ret_busy_bypass", 32'(rd_busy[0]), 32'h0);
        tick; ret_en = 0;
        #1;
        check("drained_busy", 32'(rd_busy[0]), 32'h0);
        check("drained_no_unf", 32'(ret_unf), 32'h0);

        // Same-cycle iss/ret on r3, then underflow on r0.
        iss_en = 1; iss_addr = 2'd3;
        tick; ret_en = 1; ret_addr = 2'd3;
        tick; iss_en = 0; ret_en = 0;
        #1;
        check("same_cycle_busy", 32'(rd_busy[1]), 32'h1);
        check("same_cycle_no_ovf", 32'(iss_ovf), 32'h0);
        check("same_cycle_no_unf", 32'(ret_unf), 32'h0);
        ret_en = 1; ret_addr = 2'd3;
        tick; ret_addr = 2'd0;
        tick; ret_en = 0;
        #1;
        check("unf_pulse", 32'(ret_unf), 32'h1);
        check("r3_released", 32'(rd_busy[1]), 32'h0);
        check("retired_count", 32'(num_retired), 32'd6);
        tick;
        check("unf_pulse_end", 32'(ret_unf), 32'h0);

        // Asynchronous reset mid-operation with r2 reserved twice.
        iss_en = 1; iss_addr = 2'd2;
        tick; tick; iss_en = 0;
        wr_en = 1; wr_addr = 2'd2; wr_data = 16'h5555;
        tick; wr_en = 0; rd_addr = {2'd2, 2'd2};
        #1;
        check("pre_reset_busy", 32'(rd_busy), 32'h3);
        check("pre_reset_data", rd_data, 32'h55555555);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(rd_busy), 32'h0);
        check("async_reset_data", rd_data, 32'h0);
        check("async_reset_out_port", 32'(out_port), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic, checked each cycle by the model compare.
        for (int n = 0; n < 2000; n++) begin
            tick;
            wr_en    = 1'($urandom_range(0, 1));
            wwd      = ($urandom_range(0, 3) == 0);
            wr_addr  = 2'($urandom);
            wr_data  = 16'($urandom);
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = 2'($urandom);
            ret_en   = 1'($urandom_range(0, 1));
            ret_addr = ($urandom_range(0, 3) == 0) ? iss_addr : 2'($urandom);
            rd_addr  = 4'($urandom);
        end
        tick;
        wr_en = 0; iss_en = 0; ret_en = 0;

        // Eight-register instance: counter wrap and port-2 / invalid-address reads.
        b_ret_en = 1;
        repeat (255) tick;
        check("wrap_255", 32'(b_num_retired), 32'd255);
        tick; b_ret_en = 0;
        check("wrap_to_zero", 32'(b_num_retired), 32'd0);
        b_wr_en = 1; b_wr_addr = 4'd7; b_wr_data = 8'hA5;
        b_rd_addr = {4'd7, 4'd9, 4'd0};
        #1 check("p2_bypass_r7", 32'(b_rd_data[23:16]), 32'hA5);
        tick; b_wr_en = 0;
        #1 check("p2_read_r7", 32'(b_rd_data[23:16]), 32'hA5);
        b_wr_en = 1; b_wr_addr = 4'd9; b_wr_data = 8'h3C; b_iss_en = 1; b_iss_addr = 4'd9;
        #1 check("invalid_bypass_zero", 32'(b_rd_data[15:8]), 32'h0);
        tick; b_wr_en = 0; b_iss_en = 0;
        #1;
        check("invalid_read_zero", 32'(b_rd_data[15:8]), 32'h0);
        check("invalid_iss_ignored", 32'(b_rd_busy[1]), 32'h0);
        check("invalid_iss_no_ovf", 32'(b_iss_ovf), 32'h0);
        check("r7_intact", 32'(b_rd_data[23:16]), 32'hA5);

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
